// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer, 8N1 framing with
// optional odd/even parity and back-to-back frame support.
module uart_tx #(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int N  = p_clk_speed_hz / p_baud_rate;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic          pen_q;
  logic          tx_q;

  logic          buf_full_q;
  logic [7:0]    buf_data_q;
  logic          buf_pen_q;
  logic          buf_psel_q;

  logic bit_end;
  logic load;
  logic xfer;

  assign bit_end = (cnt_q == LAST);
  assign load    = valid_i & ~buf_full_q;
  // Leaving IDLE, or chaining straight out of STOP.
  assign xfer    = buf_full_q & enable_i &
                   ((state_q == IDLE) |
                    ((state_q == STOP) & bit_end));

  assign ready_o = ~buf_full_q;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == STOP) & bit_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || bit_end || xfer) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_pen_q  <= 1'b0;
      buf_psel_q <= 1'b0;
    end else if (load) begin
      buf_full_q <= 1'b1;
      buf_data_q <= data_i;
      buf_pen_q  <= parity_en_i;
      buf_psel_q <= parity_sel_i;
    end else if (xfer) begin
      buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
    end else if (xfer) begin
      state_q <= START;
      tx_q    <= 1'b0;
      bit_q   <= '0;
      sh_q    <= buf_data_q;
      pen_q   <= buf_pen_q;
      par_q   <= buf_psel_q ? ^buf_data_q
                            : ~^buf_data_q;
    end else if (bit_end) begin
      case (state_q)
        START: begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
        end
        DATA: begin
          if (bit_q == 3'd7) begin
            state_q <= pen_q ? PARITY : STOP;
            tx_q    <= pen_q ? par_q : 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            sh_q  <= sh_q >> 1;
            tx_q  <= sh_q[1];
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at N=10 clocks per bit.
// Drives and samples on the falling clock edge.
module tb_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       parity_en_i = 1'b0;
  logic       parity_sel_i = 1'b0;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_tx #(
    .p_clk_speed_hz(1000),
    .p_baud_rate   (100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .parity_en_i (parity_en_i),
    .parity_sel_i(parity_sel_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Present a byte for one cycle, then scramble the
  // parity inputs to show they were latched at accept.
  task automatic send(input logic [7:0] d,
                      input bit pen,
                      input bit psel);
    valid_i      = 1'b1;
    data_i       = d;
    parity_en_i  = pen;
    parity_sel_i = psel;
    @(negedge clk_i);
    valid_i      = 1'b0;
    data_i       = ~d;
    parity_en_i  = ~pen;
    parity_sel_i = ~psel;
  endtask

  task automatic expect_frame(input logic [7:0] d,
                              input bit pen,
                              input bit psel,
                              input string tag,
                              input int exp_wait);
    int nb;
    int waited;
    int dn;
    int bz;
    logic [10:0] exp;
    logic [10:0] got;
    nb  = pen ? 11 : 10;
    exp = '0;
    got = '0;
    exp[8:1] = d;
    if (pen) begin
      exp[9]  = psel ? ^d : ~^d;
      exp[10] = 1'b1;
    end else begin
      exp[9] = 1'b1;
    end
    waited = 0;
    while (tx_o !== 1'b0 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    check({tag, ".wait"}, waited, exp_wait);
    dn = 0;
    bz = 0;
    for (int c = 0; c < nb * 10; c++) begin
      if (c % 10 == 5) got[c/10] = tx_o;
      if (done_o) dn++;
      if (busy_o) bz++;
      @(negedge clk_i);
    end
    check({tag, ".bits"}, 32'(got), 32'(exp));
    check({tag, ".done"}, dn, 1);
    check({tag, ".busy"}, bz, nb * 10);
  endtask

  initial begin
    int bad;
    int dn;

    repeat (3) @(negedge clk_i);
    check("rst.tx", 32'(tx_o), 1);
    check("rst.busy", 32'(busy_o), 0);
    check("rst.done", 32'(done_o), 0);
    check("rst.ready", 32'(ready_o), 1);
    rst_i = 1'b0;

    send(8'hA5, 1'b0, 1'b0);
    expect_frame(8'hA5, 1'b0, 1'b0, "a5", 1);
    check("a5.idle", 32'(busy_o), 0);
    check("a5.ready", 32'(ready_o), 1);

    send(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b1, "even", 1);
    send(8'h07, 1'b1, 1'b0);
    expect_frame(8'h07, 1'b1, 1'b0, "odd", 1);

    send(8'h55, 1'b0, 1'b0);
    fork
      expect_frame(8'h55, 1'b0, 1'b0, "b2b0", 1);
      begin
        repeat (20) @(negedge clk_i);
        send(8'h33, 1'b0, 1'b0);
        check("b2b.full", 32'(ready_o), 0);
        send(8'hFF, 1'b0, 1'b0);
        check("b2b.drop", 32'(ready_o), 0);
      end
    join
    expect_frame(8'h33, 1'b0, 1'b0, "b2b1", 0);
    bad = 0;
    repeat (30) begin
      if (busy_o !== 1'b0 || tx_o !== 1'b1) bad++;
      @(negedge clk_i);
    end
    check("b2b.after", bad, 0);

    enable_i = 1'b0;
    send(8'h3C, 1'b0, 1'b0);
    bad = 0;
    repeat (50) begin
      if (busy_o !== 1'b0 || tx_o !== 1'b1) bad++;
      @(negedge clk_i);
    end
    check("en.hold", bad, 0);
    check("en.full", 32'(ready_o), 0);
    enable_i = 1'b1;
    expect_frame(8'h3C, 1'b0, 1'b0, "en", 1);

    send(8'h00, 1'b0, 1'b0);
    bad = 0;
    while (tx_o !== 1'b0 && bad < 200) begin
      @(negedge clk_i);
      bad++;
    end
    check("ar.wait", bad, 1);
    send(8'h99, 1'b0, 1'b0);
    repeat (34) @(negedge clk_i);
    check("ar.pre_tx", 32'(tx_o), 0);
    check("ar.pre_rdy", 32'(ready_o), 0);
    #2 rst_i = 1'b1;
    #1;
    check("ar.tx", 32'(tx_o), 1);
    check("ar.busy", 32'(busy_o), 0);
    check("ar.ready", 32'(ready_o), 1);
    dn = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    check("ar.done", dn, 0);
    rst_i = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0, "post", 1);
    bad = 0;
    repeat (20) begin
      if (busy_o !== 1'b0) bad++;
      @(negedge clk_i);
    end
    check("post.idle", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
